// File: rtl/ieee_accumulator_if.sv
// Operand stream and result bundle for ieee_accumulator.
// master: upstream/source side; slave: accumulator side.
interface ieee_accumulator_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        acc_valid;
   logic [31:0] acc_out;
   logic        busy;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, acc_valid, acc_out, busy
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, acc_valid, acc_out, busy
   );
endinterface

// File: rtl/ieee_accumulator.sv
// Multi-cycle IEEE-754 single-precision accumulator (acc += in_data).
// Ports: clk, rst (sync, active high); bus (slave): in_valid/in_ready/
// in_data/in_last operand stream, acc_valid/acc_out result, busy.
module ieee_accumulator (
   input  logic              clk,
   input  logic              rst,
   ieee_accumulator_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t state_q, state_d;
   logic   in_ready, acc_valid, busy, hs;

   logic [31:0] acc_q, out_q, data_q;
   logic        last_q;

   // ALIGN results
   logic        sign_q, sign_d;
   logic [7:0]  exp_q, exp_d;
   logic [26:0] big_q, big_d;
   logic [26:0] sml_q, sml_d;
   logic        sub_q, sub_d;
   logic        spec_q, spec_d;
   logic [31:0] spv_q, spv_d;
   // ADD result
   logic [27:0] sum_q, sum_d;
   // NORM results
   logic signed [9:0] nexp_q, nexp_d;
   logic [26:0] norm_q, norm_d;
   logic        zero_q, zero_d;
   // ROUND result
   logic [31:0] res;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      acc_valid = 1'b0;
      busy      = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            in_ready = !rst;
            if (bus.in_valid && !rst) state_d = S_ALIGN;
         end
         S_ALIGN: state_d = S_ADD;
         S_ADD:   state_d = S_NORM;
         S_NORM:  state_d = S_ROUND;
         S_ROUND: begin
            acc_valid = last_q && !rst;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign hs            = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.acc_valid = acc_valid;
   assign bus.busy      = busy;
   assign bus.acc_out   = acc_valid ? res : out_q;

   // ---------------- ALIGN ----------------
   logic        a_s, b_s, a_nan, b_nan, a_inf, b_inf, swap;
   logic [7:0]  a_e, b_e, s_e, ediff;
   logic [22:0] a_f, b_f;
   logic [23:0] a_m, b_m, s_m;
   logic [26:0] s_ext, s_sh, s_lost;

   always_comb begin
      {a_s, a_e, a_f} = acc_q;
      {b_s, b_e, b_f} = data_q;
      a_nan = (a_e == 8'hFF) && (a_f != '0);
      b_nan = (b_e == 8'hFF) && (b_f != '0);
      a_inf = (a_e == 8'hFF) && (a_f == '0);
      b_inf = (b_e == 8'hFF) && (b_f == '0);
      // denormals flush to zero
      a_m = (a_e == '0) ? '0 : {1'b1, a_f};
      b_m = (b_e == '0) ? '0 : {1'b1, b_f};
      swap = {b_e, b_m} > {a_e, a_m};

      sign_d = swap ? b_s : a_s;
      exp_d  = swap ? b_e : a_e;
      big_d  = {(swap ? b_m : a_m), 3'b000};
      s_e    = swap ? a_e : b_e;
      s_m    = swap ? a_m : b_m;
      sub_d  = a_s ^ b_s;
      ediff  = exp_d - s_e;

      s_ext  = {s_m, 3'b000};
      s_sh   = '0;
      s_lost = '0;
      if (ediff >= 8'd27) begin
         sml_d = {26'b0, |s_m};
      end else begin
         s_sh   = s_ext >> ediff;
         s_lost = s_ext & ~(27'h7FF_FFFF << ediff);
         sml_d  = {s_sh[26:1], s_sh[0] | (|s_lost)};
      end

      spec_d = 1'b0;
      spv_d  = QNAN;
      if (a_nan || b_nan || (a_inf && b_inf && sub_d)) begin
         spec_d = 1'b1;
         spv_d  = QNAN;
      end else if (a_inf) begin
         spec_d = 1'b1;
         spv_d  = acc_q;
      end else if (b_inf) begin
         spec_d = 1'b1;
         spv_d  = data_q;
      end
   end

   // ---------------- ADD ----------------
   // big_q >= sml_q by construction, so subtraction never wraps.
   always_comb begin
      if (sub_q) sum_d = {1'b0, big_q} - {1'b0, sml_q};
      else       sum_d = {1'b0, big_q} + {1'b0, sml_q};
   end

   // ---------------- NORM ----------------
   logic [4:0] lz;

   always_comb begin
      lz = 5'd27;
      for (int i = 0; i <= 26; i++) begin
         if (sum_q[i]) lz = 5'(26 - i);
      end
      zero_d = (sum_q == '0);
      if (sum_q[27]) begin
         norm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
         nexp_d = $signed({2'b00, exp_q}) + 10'sd1;
      end else begin
         norm_d = sum_q[26:0] << lz;
         nexp_d = $signed({2'b00, exp_q}) - $signed({5'b0, lz});
      end
   end

   // ---------------- ROUND ----------------
   logic              up;
   logic [24:0]       m25;
   logic signed [9:0] rexp;
   logic [22:0]       rman;

   always_comb begin
      // G = bit 2, R|S = bits 1:0, LSB = bit 3
      up   = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
      m25  = {1'b0, norm_q[26:3]} + {24'b0, up};
      rexp = m25[24] ? nexp_q + 10'sd1 : nexp_q;
      rman = m25[24] ? m25[23:1] : m25[22:0];
      if (spec_q)
         res = spv_q;
      else if (zero_q)
         res = sub_q ? 32'h0 : {sign_q, 31'h0};
      else if (rexp <= 10'sd0)
         res = {sign_q, 31'h0};
      else if (rexp >= 10'sd255)
         res = {sign_q, 8'hFF, 23'h0};
      else
         res = {sign_q, rexp[7:0], rman};
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         out_q  <= '0;
         data_q <= '0;
         last_q <= 1'b0;
         sign_q <= 1'b0;
         exp_q  <= '0;
         big_q  <= '0;
         sml_q  <= '0;
         sub_q  <= 1'b0;
         spec_q <= 1'b0;
         spv_q  <= '0;
         sum_q  <= '0;
         nexp_q <= '0;
         norm_q <= '0;
         zero_q <= 1'b0;
      end else begin
         if (hs) begin
            data_q <= bus.in_data;
            last_q <= bus.in_last;
         end
         if (state_q == S_ALIGN) begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            big_q  <= big_d;
            sml_q  <= sml_d;
            sub_q  <= sub_d;
            spec_q <= spec_d;
            spv_q  <= spv_d;
         end
         if (state_q == S_ADD) sum_q <= sum_d;
         if (state_q == S_NORM) begin
            nexp_q <= nexp_d;
            norm_q <= norm_d;
            zero_q <= zero_d;
         end
         if (state_q == S_ROUND) begin
            acc_q <= last_q ? 32'h0 : res;
            if (last_q) out_q <= res;
         end
      end
   end
endmodule

// File: tb/tb_ieee_accumulator.sv
// Bench for ieee_accumulator: directed cases plus random sums
// checked against an exact-arithmetic reference model.
module tb_ieee_accumulator;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   pulses = 0;
   logic [31:0] acc_m = 32'h0;
   logic [31:0] out_m = 32'h0;

   ieee_accumulator_if bus();

   ieee_accumulator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.acc_valid) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Exact sum in units of 2^-149, then one RNE rounding.
   function automatic logic [31:0] fadd(input logic [31:0] a,
                                        input logic [31:0] b);
      logic [299:0] ma, mb, mag, rem, half, one;
      logic         sa, sb, rs;
      int           ea, eb, p, e;
      logic [24:0]  m;
      sa = a[31];
      sb = b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
         return 32'h7FC00000;
      if (ea == 255 && eb == 255) return (sa == sb) ? a : 32'h7FC00000;
      if (ea == 255) return a;
      if (eb == 255) return b;
      one = 300'd1;
      ma = (ea == 0) ? 300'd0 : ({276'd0, 1'b1, a[22:0]} << (ea - 1));
      mb = (eb == 0) ? 300'd0 : ({276'd0, 1'b1, b[22:0]} << (eb - 1));
      if (sa == sb) begin
         mag = ma + mb; rs = sa;
      end else if (ma >= mb) begin
         mag = ma - mb; rs = sa;
      end else begin
         mag = mb - ma; rs = sb;
      end
      if (mag == 0) return (sa == sb) ? {sa, 31'b0} : 32'h0;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      e = p - 22;
      if (p >= 24) begin
         m    = 25'(mag >> (p - 23));
         rem  = mag & ((one << (p - 23)) - one);
         half = one << (p - 24);
         if (rem > half || (rem == half && m[0])) m = m + 25'd1;
      end else begin
         m = 25'(mag << (23 - p));
      end
      if (m[24]) begin
         m = m >> 1;
         e++;
      end
      if (e <= 0) return {rs, 31'b0};
      if (e >= 255) return {rs, 8'hFF, 23'b0};
      return {rs, 8'(e), m[22:0]};
   endfunction

   // one operand through the full handshake/latency sequence
   task automatic do_op(input logic [31:0] d, input logic last,
                        input logic junk, input logic use_want,
                        input logic [31:0] want);
      int n;
      int p0;
      logic [31:0] expv;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hs_wait", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      acc_m = fadd(acc_m, d);
      expv  = use_want ? want : acc_m;
      if (last) acc_m = 32'h0;
      p0 = pulses;
      if (junk) begin
         bus.in_data = $urandom;
         bus.in_last = ~last;
      end else begin
         bus.in_valid = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         chk("rdy_low", {31'b0, bus.in_ready}, 32'd0);
         chk("busy", {31'b0, bus.busy}, 32'd1);
         chk("vld", {31'b0, bus.acc_valid}, {31'b0, (k == 3) && last});
         if (k == 3 && last) chk("sum", bus.acc_out, expv);
         else                chk("hold", bus.acc_out, out_m);
      end
      bus.in_valid = 1'b0;
      if (last) out_m = expv;
      @(posedge clk); #1;
      chk("rdy_back", {31'b0, bus.in_ready}, 32'd1);
      chk("pulses", 32'(pulses - p0), {31'b0, last});
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] r;
      r[31]    = 1'($urandom_range(0, 1));
      r[30:23] = 8'($urandom_range(110, 145));
      r[22:0]  = 23'($urandom);
      if ($urandom_range(0, 15) == 0) r[30:0] = 31'h0;
      return r;
   endfunction

   initial begin
      int n;
      int p0;
      logic [31:0] op;
      logic [31:0] prev;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", {31'b0, bus.in_ready}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_vld", {31'b0, bus.acc_valid}, 32'd0);
      chk("rst_out", bus.acc_out, 32'h0);
      rst = 1'b0;
      #1;
      chk("rdy_after_rst", {31'b0, bus.in_ready}, 32'd1);

      do_op(32'h40000000, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'h40400000, 1'b1, 1'b0, 1'b1, 32'h40A00000);
      do_op(32'h414BCF04, 1'b0, 1'b1, 1'b0, 32'h0);
      do_op(32'h414BCF04, 1'b1, 1'b1, 1'b1, 32'h41CBCF04);
      do_op(32'h4B800000, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'h3F800000, 1'b1, 1'b0, 1'b1, 32'h4B800000);
      do_op(32'h3F800000, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'hBF800000, 1'b1, 1'b0, 1'b1, 32'h00000000);
      do_op(32'h3F800000, 1'b1, 1'b0, 1'b1, 32'h3F800000);
      do_op(32'h7F800000, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'hFF800000, 1'b1, 1'b0, 1'b1, 32'h7FC00000);
      do_op(32'h7F7FFFFF, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'h7F7FFFFF, 1'b1, 1'b0, 1'b1, 32'h7F800000);
      do_op(32'h7FC00001, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'h3F800000, 1'b1, 1'b0, 1'b1, 32'h7FC00000);
      do_op(32'hFF800000, 1'b0, 1'b0, 1'b0, 32'h0);
      do_op(32'h42000000, 1'b1, 1'b0, 1'b1, 32'hFF800000);
      do_op(32'h00400000, 1'b1, 1'b0, 1'b1, 32'h00000000);

      // reset during NORM must abort without a result
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F800000;
      bus.in_last  = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_hs_wait", 32'(n < 20), 32'd1);
      p0 = pulses;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("abort_busy", {31'b0, bus.busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_vld", {31'b0, bus.acc_valid}, 32'd0);
      chk("abort_out", bus.acc_out, 32'h0);
      chk("abort_busy0", {31'b0, bus.busy}, 32'd0);
      chk("abort_rdy0", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_rdy1", {31'b0, bus.in_ready}, 32'd1);
      chk("abort_pulses", 32'(pulses - p0), 32'd0);
      acc_m = 32'h0;
      out_m = 32'h0;
      do_op(32'h40000000, 1'b1, 1'b0, 1'b1, 32'h40000000);

      // random sums, some with near-cancelling operand pairs
      prev = 32'h0;
      for (int s = 0; s < 30; s++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            op = rnd_op();
            if (i > 0 && $urandom_range(0, 3) == 0)
               op = {~prev[31], prev[30:4], 4'($urandom)};
            prev = op;
            do_op(op, 1'(i == n - 1), 1'($urandom_range(0, 1)),
                  1'b0, 32'h0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
